// File: rtl/uart_config_parser_pkg.sv
// Shared constants, state encoding and frame payload for the UART configuration parser.
package uart_config_parser_pkg;

    localparam int unsigned BYTE_W   = 8;
    localparam int unsigned DELAY_W  = 16;
    localparam int unsigned NUM_CH   = 8;
    localparam int unsigned ALINES_W = 5;
    localparam int unsigned PULSE_W  = 32;
    localparam int unsigned STATE_W  = 3;
    localparam int unsigned DELAY_FLAT_W = NUM_CH * DELAY_W;

    localparam logic [BYTE_W-1:0] SYNC_BYTE_DEFAULT = 8'hA5;

    localparam logic [BYTE_W-1:0] ADDR_DELAY_LAST = 8'h07;
    localparam logic [BYTE_W-1:0] ADDR_USED_CH    = 8'h08;
    localparam logic [BYTE_W-1:0] ADDR_NUM_ALINES = 8'h09;
    localparam logic [BYTE_W-1:0] ADDR_PULSE_HI   = 8'h0A;
    localparam logic [BYTE_W-1:0] ADDR_PULSE_LO   = 8'h0B;
    localparam logic [BYTE_W-1:0] ADDR_START      = 8'h0F;

    typedef enum logic [STATE_W-1:0] {
        PARSE_IDLE     = 3'd0,
        PARSE_GET_ADDR = 3'd1,
        PARSE_GET_DHI  = 3'd2,
        PARSE_GET_DLO  = 3'd3,
        PARSE_GET_CSUM = 3'd4,
        PARSE_COMMIT   = 3'd5
    } parser_state_e;

    typedef struct packed {
        logic [BYTE_W-1:0] addr;
        logic [BYTE_W-1:0] dhi;
        logic [BYTE_W-1:0] dlo;
    } cfg_frame_t;

    function automatic logic [BYTE_W-1:0] frame_csum(input cfg_frame_t f);
        return f.addr ^ f.dhi ^ f.dlo;
    endfunction

    // Addresses 0x00..0x0B map onto writable configuration registers.
    function automatic logic addr_is_reg(input logic [BYTE_W-1:0] a);
        return a <= ADDR_PULSE_LO;
    endfunction

endpackage

// File: rtl/uart_config_parser_if.sv
// Byte input, control and configuration output bundle of the parser.
interface uart_config_parser_if;
    import uart_config_parser_pkg::*;

    logic [BYTE_W-1:0]       rx_data;
    logic                    rx_new;
    logic                    xmit_busy;
    logic                    mem_clear;
    logic [DELAY_FLAT_W-1:0] delay_flat;
    logic [NUM_CH-1:0]       used_channels;
    logic [ALINES_W-1:0]     num_alines;
    logic [PULSE_W-1:0]      pulse_shape;
    logic                    start_us;
    logic                    cfg_update;
    logic                    frame_err;
    logic [STATE_W-1:0]      parser_state;

    modport master (
        output rx_data, rx_new, xmit_busy, mem_clear,
        input  delay_flat, used_channels, num_alines, pulse_shape,
               start_us, cfg_update, frame_err, parser_state
    );

    modport slave (
        input  rx_data, rx_new, xmit_busy, mem_clear,
        output delay_flat, used_channels, num_alines, pulse_shape,
               start_us, cfg_update, frame_err, parser_state
    );

endinterface

// File: rtl/uart_config_parser_rx_edge_detect.sv
// Turns the level rx_new flag into a one-cycle byte strobe on its rising edge.
module rx_edge_detect (
    input  logic clk,
    input  logic rst_n,
    input  logic rx_new,
    output logic byte_stb_c
);

    logic rx_new_d;
    logic rx_new_q;

    always_comb begin
        rx_new_d = rx_new;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_new_q <= 1'b0;
        end else begin
            rx_new_q <= rx_new_d;
        end
    end

    assign byte_stb_c = rx_new & ~rx_new_q;

endmodule

// File: rtl/uart_config_parser.sv
// Parses SYNC/ADDR/DHI/DLO/CSUM frames from the UART and commits them to configuration registers.
module uart_config_parser
    import uart_config_parser_pkg::*;
#(
    parameter logic [7:0]  SYNC_BYTE      = SYNC_BYTE_DEFAULT,
    parameter int unsigned TIMEOUT_CYCLES = 1_000_000
) (
    input logic                 clk,
    input logic                 rst_n,
    uart_config_parser_if.slave bus
);

    localparam int unsigned       CNT_W   = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(TIMEOUT_CYCLES);

    logic byte_stb_c;
    logic timeout_c;

    parser_state_e state_q, state_d;
    cfg_frame_t    frame_q, frame_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic [NUM_CH-1:0][DELAY_W-1:0] delay_q, delay_d;
    logic [NUM_CH-1:0]   used_q, used_d;
    logic [ALINES_W-1:0] alines_q, alines_d;
    logic [PULSE_W-1:0]  pulse_q, pulse_d;
    logic start_us_q, start_us_d;
    logic cfg_update_q, cfg_update_d;
    logic frame_err_q, frame_err_d;

    rx_edge_detect u_rx_edge (
        .clk        (clk),
        .rst_n      (rst_n),
        .rx_new     (bus.rx_new),
        .byte_stb_c (byte_stb_c)
    );

    // Inter-byte watchdog only runs while a frame is being collected.
    assign timeout_c = (state_q != PARSE_IDLE) && (state_q != PARSE_COMMIT) && (cnt_q == CNT_MAX);

    always_comb begin
        state_d      = state_q;
        frame_d      = frame_q;
        cnt_d        = cnt_q;
        delay_d      = delay_q;
        used_d       = used_q;
        alines_d     = alines_q;
        pulse_d      = pulse_q;
        start_us_d   = 1'b0;
        cfg_update_d = 1'b0;
        frame_err_d  = 1'b0;

        if ((state_q == PARSE_IDLE) || byte_stb_c) begin
            cnt_d = '0;
        end else if (cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + CNT_W'(1);
        end

        case (state_q)
            PARSE_IDLE: begin
                if (byte_stb_c && (bus.rx_data == SYNC_BYTE)) begin
                    state_d = PARSE_GET_ADDR;
                end
            end
            PARSE_GET_ADDR: begin
                if (byte_stb_c) begin
                    frame_d.addr = bus.rx_data;
                    state_d      = PARSE_GET_DHI;
                end
            end
            PARSE_GET_DHI: begin
                if (byte_stb_c) begin
                    frame_d.dhi = bus.rx_data;
                    state_d     = PARSE_GET_DLO;
                end
            end
            PARSE_GET_DLO: begin
                if (byte_stb_c) begin
                    frame_d.dlo = bus.rx_data;
                    state_d     = PARSE_GET_CSUM;
                end
            end
            PARSE_GET_CSUM: begin
                if (byte_stb_c) begin
                    if (bus.rx_data == frame_csum(frame_q)) begin
                        state_d = PARSE_COMMIT;
                    end else begin
                        state_d     = PARSE_IDLE;
                        frame_err_d = 1'b1;
                    end
                end
            end
            PARSE_COMMIT: begin
                state_d = PARSE_IDLE;
                if (frame_q.addr == ADDR_START) begin
                    if (bus.xmit_busy) frame_err_d = 1'b1;
                    else               start_us_d  = 1'b1;
                end else if (!addr_is_reg(frame_q.addr) || bus.xmit_busy) begin
                    frame_err_d = 1'b1;
                end else begin
                    cfg_update_d = 1'b1;
                    if (frame_q.addr <= ADDR_DELAY_LAST) begin
                        delay_d[frame_q.addr[2:0]] = {frame_q.dhi, frame_q.dlo};
                    end else if (frame_q.addr == ADDR_USED_CH) begin
                        used_d = frame_q.dlo;
                    end else if (frame_q.addr == ADDR_NUM_ALINES) begin
                        alines_d = frame_q.dlo[ALINES_W-1:0];
                    end else if (frame_q.addr == ADDR_PULSE_HI) begin
                        pulse_d[PULSE_W-1:DELAY_W] = {frame_q.dhi, frame_q.dlo};
                    end else begin
                        pulse_d[DELAY_W-1:0] = {frame_q.dhi, frame_q.dlo};
                    end
                end
            end
            default: begin
                state_d = PARSE_IDLE;
            end
        endcase

        if (timeout_c) begin
            state_d     = PARSE_IDLE;
            frame_err_d = 1'b1;
        end

        // Clear overrides everything, including a commit in flight.
        if (bus.mem_clear) begin
            state_d      = PARSE_IDLE;
            cnt_d        = '0;
            delay_d      = '0;
            used_d       = '0;
            alines_d     = '0;
            pulse_d      = '0;
            start_us_d   = 1'b0;
            cfg_update_d = 1'b0;
            frame_err_d  = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= PARSE_IDLE;
            frame_q      <= '0;
            cnt_q        <= '0;
            delay_q      <= '0;
            used_q       <= '0;
            alines_q     <= '0;
            pulse_q      <= '0;
            start_us_q   <= 1'b0;
            cfg_update_q <= 1'b0;
            frame_err_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            frame_q      <= frame_d;
            cnt_q        <= cnt_d;
            delay_q      <= delay_d;
            used_q       <= used_d;
            alines_q     <= alines_d;
            pulse_q      <= pulse_d;
            start_us_q   <= start_us_d;
            cfg_update_q <= cfg_update_d;
            frame_err_q  <= frame_err_d;
        end
    end

    assign bus.delay_flat    = delay_q;
    assign bus.used_channels = used_q;
    assign bus.num_alines    = alines_q;
    assign bus.pulse_shape   = pulse_q;
    assign bus.start_us      = start_us_q;
    assign bus.cfg_update    = cfg_update_q;
    assign bus.frame_err     = frame_err_q;
    assign bus.parser_state  = state_q;

endmodule

// File: tb/tb_uart_config_parser.sv
// Randomized frame-level bench for uart_config_parser against a register-map reference model.
module tb_uart_config_parser;
    import uart_config_parser_pkg::*;

    localparam int unsigned TO = 40;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    uart_config_parser_if bus();

    uart_config_parser #(.SYNC_BYTE(8'hA5), .TIMEOUT_CYCLES(TO)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    int total = 0;
    int bad   = 0;

    // Observed pulse-cycle counts and expected counts from the model.
    int n_err = 0, n_cfg = 0, n_start = 0;
    int e_err = 0, e_cfg = 0, e_start = 0;

    logic [15:0] m_delay [8];
    logic [7:0]  m_used;
    logic [4:0]  m_alines;
    logic [31:0] m_pulse;
    logic [127:0] exp_flat;

    always @(posedge clk) begin
        if (bus.frame_err)  n_err   <= n_err + 1;
        if (bus.cfg_update) n_cfg   <= n_cfg + 1;
        if (bus.start_us)   n_start <= n_start + 1;
    end

    task automatic model_clear();
        for (int c = 0; c < 8; c++) m_delay[c] = 16'h0;
        m_used   = 8'h0;
        m_alines = 5'h0;
        m_pulse  = 32'h0;
    endtask

    // Outcome of one complete frame, decided from the register map rules.
    task automatic model_frame(input logic [7:0] a, input logic [7:0] dh, input logic [7:0] dl,
                               input logic [7:0] cs, input logic busy);
        if (cs != (a ^ dh ^ dl)) e_err++;
        else if (a == 8'h0F) begin
            if (busy) e_err++;
            else      e_start++;
        end else if (a > 8'h0B || busy) e_err++;
        else begin
            e_cfg++;
            if (a < 8'h08)       m_delay[a] = {dh, dl};
            else if (a == 8'h08) m_used = dl;
            else if (a == 8'h09) m_alines = dl[4:0];
            else if (a == 8'h0A) m_pulse[31:16] = {dh, dl};
            else                 m_pulse[15:0]  = {dh, dl};
        end
    endtask

    task automatic build_flat();
        for (int c = 0; c < 8; c++) exp_flat[c*16 +: 16] = m_delay[c];
    endtask

    task automatic send_byte(input logic [7:0] b);
        int hold;
        int gap;
        hold = int'($urandom_range(1, 3));
        gap  = int'($urandom_range(1, 3));
        bus.rx_data = b;
        bus.rx_new  = 1'b1;
        repeat (hold) @(posedge clk);
        #1;
        bus.rx_new = 1'b0;
        repeat (gap) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] a, input logic [7:0] dh, input logic [7:0] dl,
                              input logic [7:0] cs);
        send_byte(8'hA5);
        send_byte(a);
        send_byte(dh);
        send_byte(dl);
        send_byte(cs);
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [178:0] outs;
        rst_n = 1'b0;
        #3;
        outs = {bus.delay_flat, bus.used_channels, bus.num_alines, bus.pulse_shape,
                bus.start_us, bus.cfg_update, bus.frame_err, bus.parser_state};
        total++;
        if (outs !== '0) begin
            bad++;
            $display("FAIL reset_outputs: got %h want 0", outs);
        end
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        total++;
        if (bus.parser_state !== 3'd0) begin
            bad++;
            $display("FAIL reset_state: got %0d want 0", bus.parser_state);
        end
    endtask

    task automatic test_write_timing();
        send_byte(8'hA5);
        send_byte(8'h03);
        send_byte(8'h12);
        send_byte(8'h34);
        bus.rx_data = 8'h25;
        bus.rx_new  = 1'b1;
        @(posedge clk);
        #1;
        total++;
        if (bus.parser_state !== 3'd5 || bus.delay_flat[63:48] !== m_delay[3] || bus.cfg_update !== 1'b0) begin
            bad++;
            $display("FAIL commit_cycle: got state=%0d ch3=%h cfg=%b want state=5 ch3=%h cfg=0",
                     bus.parser_state, bus.delay_flat[63:48], bus.cfg_update, m_delay[3]);
        end
        model_frame(8'h03, 8'h12, 8'h34, 8'h25, 1'b0);
        @(posedge clk);
        #1;
        total++;
        if (bus.delay_flat[63:48] !== 16'h1234 || bus.cfg_update !== 1'b1 ||
            bus.frame_err !== 1'b0 || bus.parser_state !== 3'd0) begin
            bad++;
            $display("FAIL write_visible: got ch3=%h cfg=%b err=%b state=%0d want 1234 1 0 0",
                     bus.delay_flat[63:48], bus.cfg_update, bus.frame_err, bus.parser_state);
        end
        repeat (3) @(posedge clk);
        #1;
        bus.rx_new = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        total++;
        if (n_cfg !== e_cfg || n_err !== e_err) begin
            bad++;
            $display("FAIL write_pulses: got cfg=%0d err=%0d want cfg=%0d err=%0d", n_cfg, n_err, e_cfg, e_err);
        end
    endtask

    task automatic test_bad_csum();
        send_frame(8'h08, 8'h00, 8'h0F, 8'h00);
        model_frame(8'h08, 8'h00, 8'h0F, 8'h00, 1'b0);
        total++;
        if (n_err !== e_err || bus.used_channels !== 8'h00) begin
            bad++;
            $display("FAIL bad_csum: got err=%0d used=%h want err=%0d used=00", n_err, bus.used_channels, e_err);
        end
    endtask

    task automatic test_held_rx_new();
        bus.rx_data = 8'hA5;
        bus.rx_new  = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        total++;
        if (bus.parser_state !== 3'd1) begin
            bad++;
            $display("FAIL held_rx_new: got state=%0d want 1", bus.parser_state);
        end
        bus.rx_new = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_timeout();
        send_byte(8'h01);
        repeat (TO - 10) @(posedge clk);
        #1;
        total++;
        if (bus.parser_state !== 3'd2 || n_err !== e_err) begin
            bad++;
            $display("FAIL timeout_early: got state=%0d err=%0d want 2 %0d", bus.parser_state, n_err, e_err);
        end
        repeat (20) @(posedge clk);
        #1;
        e_err++;
        total++;
        if (bus.parser_state !== 3'd0 || n_err !== e_err || bus.delay_flat[31:16] !== m_delay[1]) begin
            bad++;
            $display("FAIL timeout: got state=%0d err=%0d ch1=%h want 0 %0d %h",
                     bus.parser_state, n_err, bus.delay_flat[31:16], e_err, m_delay[1]);
        end
    endtask

    task automatic test_start();
        bus.xmit_busy = 1'b0;
        send_frame(8'h0F, 8'h00, 8'h00, 8'h0F);
        model_frame(8'h0F, 8'h00, 8'h00, 8'h0F, 1'b0);
        total++;
        if (n_start !== e_start || n_cfg !== e_cfg || n_err !== e_err) begin
            bad++;
            $display("FAIL start_idle: got st=%0d cfg=%0d err=%0d want %0d %0d %0d",
                     n_start, n_cfg, n_err, e_start, e_cfg, e_err);
        end
        bus.xmit_busy = 1'b1;
        send_frame(8'h0F, 8'h00, 8'h00, 8'h0F);
        model_frame(8'h0F, 8'h00, 8'h00, 8'h0F, 1'b1);
        bus.xmit_busy = 1'b0;
        total++;
        if (n_start !== e_start || n_err !== e_err) begin
            bad++;
            $display("FAIL start_busy: got st=%0d err=%0d want %0d %0d", n_start, n_err, e_start, e_err);
        end
    endtask

    task automatic test_reject();
        logic [7:0] a;
        logic [7:0] dh;
        logic [7:0] dl;
        for (int i = 0; i < 6; i++) begin
            a  = (i % 2 == 0) ? 8'($urandom_range(8'h0C, 8'h0E)) : 8'($urandom_range(8'h10, 8'hFF));
            dh = 8'($urandom);
            dl = 8'($urandom);
            send_frame(a, dh, dl, a ^ dh ^ dl);
            model_frame(a, dh, dl, a ^ dh ^ dl, 1'b0);
        end
        bus.xmit_busy = 1'b1;
        send_frame(8'h0A, 8'hDE, 8'hAD, 8'h0A ^ 8'hDE ^ 8'hAD);
        model_frame(8'h0A, 8'hDE, 8'hAD, 8'h0A ^ 8'hDE ^ 8'hAD, 1'b1);
        bus.xmit_busy = 1'b0;
        build_flat();
        total++;
        if (n_err !== e_err || n_cfg !== e_cfg || bus.pulse_shape !== m_pulse || bus.delay_flat !== exp_flat) begin
            bad++;
            $display("FAIL reject: got err=%0d cfg=%0d pulse=%h want %0d %0d %h", n_err, n_cfg, bus.pulse_shape,
                     e_err, e_cfg, m_pulse);
        end
        send_frame(8'h0A, 8'hA5, 8'hA5, 8'h0A);
        model_frame(8'h0A, 8'hA5, 8'hA5, 8'h0A, 1'b0);
        total++;
        if (bus.pulse_shape !== m_pulse || n_cfg !== e_cfg) begin
            bad++;
            $display("FAIL sync_as_data: got pulse=%h cfg=%0d want %h %0d", bus.pulse_shape, n_cfg, m_pulse, e_cfg);
        end
    endtask

    task automatic test_random();
        logic [7:0] a;
        logic [7:0] dh;
        logic [7:0] dl;
        logic [7:0] cs;
        logic [7:0] junk;
        logic busy;
        for (int i = 0; i < 40; i++) begin
            a    = ($urandom_range(0, 9) == 0) ? 8'($urandom) : 8'($urandom_range(0, 15));
            dh   = 8'($urandom);
            dl   = 8'($urandom);
            cs   = a ^ dh ^ dl;
            if ($urandom_range(0, 7) == 0) cs = cs ^ 8'($urandom_range(1, 255));
            busy = ($urandom_range(0, 5) == 0);
            bus.xmit_busy = busy;
            for (int j = 0; j < int'($urandom_range(0, 2)); j++) begin
                junk = 8'($urandom);
                if (junk == 8'hA5) junk = 8'h5A;
                send_byte(junk);
            end
            send_frame(a, dh, dl, cs);
            model_frame(a, dh, dl, cs, busy);
            build_flat();
            total++;
            if (bus.delay_flat !== exp_flat || bus.used_channels !== m_used ||
                bus.num_alines !== m_alines || bus.pulse_shape !== m_pulse) begin
                bad++;
                $display("FAIL rand_regs[%0d]: addr=%h got used=%h al=%h pulse=%h flat=%h want %h %h %h %h",
                         i, a, bus.used_channels, bus.num_alines, bus.pulse_shape, bus.delay_flat,
                         m_used, m_alines, m_pulse, exp_flat);
            end
            total++;
            if (n_err !== e_err || n_cfg !== e_cfg || n_start !== e_start || bus.parser_state !== 3'd0) begin
                bad++;
                $display("FAIL rand_pulses[%0d]: addr=%h got err=%0d cfg=%0d st=%0d state=%0d want %0d %0d %0d 0",
                         i, a, n_err, n_cfg, n_start, bus.parser_state, e_err, e_cfg, e_start);
            end
        end
        bus.xmit_busy = 1'b0;
    endtask

    task automatic test_mem_clear();
        send_frame(8'h09, 8'h00, 8'hFF, 8'hF6);
        model_frame(8'h09, 8'h00, 8'hFF, 8'hF6, 1'b0);
        total++;
        if (bus.num_alines !== 5'h1F) begin
            bad++;
            $display("FAIL alines_trunc: got %h want 1f", bus.num_alines);
        end
        bus.mem_clear = 1'b1;
        @(posedge clk);
        #1;
        bus.mem_clear = 1'b0;
        model_clear();
        total++;
        if (bus.num_alines !== 5'h0 || bus.delay_flat !== '0 || bus.used_channels !== 8'h0 ||
            bus.pulse_shape !== 32'h0 || bus.frame_err !== 1'b0) begin
            bad++;
            $display("FAIL mem_clear: got al=%h used=%h pulse=%h err=%b want all 0",
                     bus.num_alines, bus.used_channels, bus.pulse_shape, bus.frame_err);
        end
        send_byte(8'hA5);
        send_byte(8'h08);
        send_byte(8'h00);
        send_byte(8'h3C);
        bus.rx_data = 8'h34;
        bus.rx_new  = 1'b1;
        @(posedge clk);
        #1;
        bus.mem_clear = 1'b1;
        @(posedge clk);
        #1;
        bus.mem_clear = 1'b0;
        bus.rx_new    = 1'b0;
        total++;
        if (bus.used_channels !== 8'h00 || bus.cfg_update !== 1'b0 || bus.parser_state !== 3'd0) begin
            bad++;
            $display("FAIL clear_vs_commit: got used=%h cfg=%b state=%0d want 00 0 0",
                     bus.used_channels, bus.cfg_update, bus.parser_state);
        end
        repeat (2) @(posedge clk);
        #1;
        total++;
        if (n_err !== e_err || n_cfg !== e_cfg) begin
            bad++;
            $display("FAIL clear_pulses: got err=%0d cfg=%0d want %0d %0d", n_err, n_cfg, e_err, e_cfg);
        end
    endtask

    task automatic test_reset_mid_frame();
        logic [178:0] outs;
        send_frame(8'h08, 8'h00, 8'h3C, 8'h34);
        model_frame(8'h08, 8'h00, 8'h3C, 8'h34, 1'b0);
        send_frame(8'h0B, 8'h77, 8'h66, 8'h0B ^ 8'h77 ^ 8'h66);
        model_frame(8'h0B, 8'h77, 8'h66, 8'h0B ^ 8'h77 ^ 8'h66, 1'b0);
        send_byte(8'hA5);
        send_byte(8'h03);
        send_byte(8'h12);
        rst_n = 1'b0;
        #2;
        model_clear();
        outs = {bus.delay_flat, bus.used_channels, bus.num_alines, bus.pulse_shape,
                bus.start_us, bus.cfg_update, bus.frame_err, bus.parser_state};
        total++;
        if (outs !== '0) begin
            bad++;
            $display("FAIL async_reset: got %h want 0", outs);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        send_frame(8'h05, 8'hAB, 8'hCD, 8'h63);
        model_frame(8'h05, 8'hAB, 8'hCD, 8'h63, 1'b0);
        total++;
        if (bus.delay_flat[95:80] !== 16'hABCD || bus.used_channels !== 8'h00 || n_cfg !== e_cfg) begin
            bad++;
            $display("FAIL after_reset: got ch5=%h used=%h cfg=%0d want abcd 00 %0d",
                     bus.delay_flat[95:80], bus.used_channels, n_cfg, e_cfg);
        end
    endtask

    initial begin
        bus.rx_data   = 8'h00;
        bus.rx_new    = 1'b0;
        bus.xmit_busy = 1'b0;
        bus.mem_clear = 1'b0;
        model_clear();
        test_reset();
        test_write_timing();
        test_bad_csum();
        test_held_rx_new();
        test_timeout();
        test_start();
        test_reject();
        test_random();
        test_mem_clear();
        test_reset_mid_frame();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/uart_config_parser.md
UART_CONFIG_PARSER -- requirements
Module: uart_config_parser

Interface
REQ-001 Parameter SYNC_BYTE, default 8'hA5, frame start marker.
REQ-002 Parameter TIMEOUT_CYCLES, default 1_000_000, maximum clk cycles allowed between bytes of one frame.
REQ-003 clk  input  1  single system clock; all logic on posedge clk.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 rx_data  input  8  byte from uart_receive.
REQ-006 rx_new  input  1  uart_receive new-data flag, level, may stay high several cycles.
REQ-007 xmit_busy  input  1  image transmit FSM busy; configuration locked while high.
REQ-008 mem_clear  input  1  one-cycle request to clear all configuration registers.
REQ-009 delay_flat  output  128  delay_ch0..7, 16 b each, ch0 in [15:0].
REQ-010 used_channels  output  8  channel enable mask.
REQ-011 num_alines  output  5  A-lines per image.
REQ-012 pulse_shape  output  32  pulse pattern word.
REQ-013 start_us  output  1  one-cycle start request to image transmit FSM.
REQ-014 cfg_update  output  1  one-cycle pulse after any register write commits.
REQ-015 frame_err  output  1  one-cycle pulse on any rejected frame.
REQ-016 parser_state  output  3  current FSM state, for LED debug.

Function
REQ-017 Byte accepted only on the rising edge of rx_new (registered previous value); a held-high rx_new yields exactly one byte.
REQ-018 Frame = SYNC, ADDR, DHI, DLO, CSUM; CSUM = ADDR ^ DHI ^ DLO.
REQ-019 States: IDLE(0), GET_ADDR(1), GET_DHI(2), GET_DLO(3), GET_CSUM(4), COMMIT(5).
REQ-020 IDLE: byte == SYNC_BYTE -> GET_ADDR; any other byte discarded silently, no frame_err.
REQ-021 GET_ADDR -> GET_DHI -> GET_DLO -> GET_CSUM on each accepted byte, latching the byte.
REQ-022 GET_CSUM: match -> COMMIT; mismatch -> IDLE with frame_err for one cycle.
REQ-023 COMMIT lasts exactly one cycle, then IDLE; write visible on outputs the cycle after COMMIT, with cfg_update high that same cycle.
REQ-024 Address map: 0x00-0x07 delay_chN = {DHI,DLO}; 0x08 used_channels = DLO; 0x09 num_alines = DLO[4:0]; 0x0A pulse_shape[31:16]; 0x0B pulse_shape[15:0]; 0x0F start command.
REQ-025 Address 0x0F: start_us pulses one cycle after COMMIT, no register changes, no cfg_update; ignored with frame_err if xmit_busy.
REQ-026 Unmapped address (0x0C-0x0E, 0x10-0xFF): no write, frame_err pulse.
REQ-027 xmit_busy high in COMMIT: register write dropped, frame_err pulse.
REQ-028 Inter-byte counter resets on each accepted byte; reaching TIMEOUT_CYCLES in any non-IDLE state -> IDLE with frame_err; counter saturates, never wraps.
REQ-029 SYNC_BYTE value received mid-frame is treated as data, not resynchronisation.
REQ-030 mem_clear: all config registers zero next cycle, FSM -> IDLE, no frame_err; mem_clear wins over a simultaneous COMMIT.
REQ-031 Values wider than the field are truncated to the LSBs; no saturation.

Reset
REQ-032 rst_n low: FSM IDLE, all config outputs 0, start_us/cfg_update/frame_err 0, edge register 0, timeout counter 0, immediately and asynchronously.
REQ-033 Reset mid-frame discards the partial frame; first frame after release is parsed normally.

Structure
REQ-034 State encodings, register address constants and SYNC_BYTE default reside in the shared uart defines header beside the MAIN_* states.
REQ-035 One sub-module, rx_edge_detect, producing the one-cycle byte strobe; all else in uart_config_parser.

Verification
REQ-036 Frame A5 03 12 34 25 -> delay_flat[63:48] = 16'h1234, one cycle cfg_update, no frame_err.
REQ-037 Frame A5 08 00 0F 07 with bad CSUM 00 -> frame_err one cycle, used_channels unchanged at 0.
REQ-038 rx_new held high 10 cycles with A5 -> one byte accepted, parser_state = 1.
REQ-039 A5 01 sent, then TIMEOUT_CYCLES idle -> frame_err, parser_state = 0, delay_ch1 unchanged.
REQ-040 Frame A5 0F 00 00 0F with xmit_busy = 0 -> start_us one cycle; same with xmit_busy = 1 -> frame_err, no start_us.
REQ-041 Write num_alines 0x1F, then mem_clear -> num_alines = 0 next cycle; rst_n low mid-frame -> all outputs 0 asynchronously.
